// File: rtl/gpio_pkg.sv
// GPIO peripheral shared definitions.
// Register offsets, window geometry and the byte-lane helper.
package gpio_pkg;

  localparam int GPIO_WIN_BYTES = 32;
  localparam int GPIO_OFF_W     = 3;

  typedef logic [GPIO_OFF_W-1:0] gpio_off_t;

  localparam gpio_off_t GPIO_OFF_OUT  = 3'd0;
  localparam gpio_off_t GPIO_OFF_OE   = 3'd1;
  localparam gpio_off_t GPIO_OFF_IN   = 3'd2;
  localparam gpio_off_t GPIO_OFF_SET  = 3'd3;
  localparam gpio_off_t GPIO_OFF_CLR  = 3'd4;
  localparam gpio_off_t GPIO_OFF_TOG  = 3'd5;
  localparam gpio_off_t GPIO_OFF_IEN  = 3'd6;
  localparam gpio_off_t GPIO_OFF_STAT = 3'd7;

  function automatic logic [31:0] gpio_lane_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    m = '0;
    for (int n = 0; n < 4; n++) begin
      m[8*n +: 8] = {8{be[n]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_periph_if.sv
// CPU data-bus slice seen by the GPIO peripheral.
// Request fields come from the core, data_out is the registered reply.
interface gpio_periph_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              write;
  logic [3:0]        width;
  logic [31:0]       data_out;

  modport master (
    output address,
    output data_in,
    output write,
    output width,
    input  data_out
  );

  modport slave (
    input  address,
    input  data_in,
    input  write,
    input  width,
    output data_out
  );
endinterface

// File: rtl/gpio_sync.sv
// Pin input synchroniser with optional rising-edge detect.
// Build with GPIO_IRQ_EN to get the delay flop and rise output.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] in_sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = in_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign in_sync_o = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
    end else begin
      dly_q <= in_sync_o;
    end
  end

  // both flops clear together, so no edge right after reset
  assign rise_o = in_sync_o & ~dly_q;
`else
  assign rise_o = '0;
`endif

endmodule

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO: direction, sync inputs, atomics, lane writes.
// Edge interrupts exist only when built with GPIO_IRQ_EN.
module gpio_periph
  import gpio_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'h3E0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  gpio_periph_if.slave     bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             sel;
  logic             we;
  gpio_off_t        off;
  logic [31:0]      lane_m;
  logic [31:0]      din_m;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ien_rd;
  logic [WIDTH-1:0] stat_rd;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [31:0]      rdata_q, rdata_d;

  assign sel    = bus.address[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5];
  assign off    = bus.address[4:2];
  assign we     = sel & bus.write;
  assign lane_m = gpio_lane_mask(bus.width);
  assign din_m  = bus.data_in & lane_m;
  assign wmask  = lane_m[WIDTH-1:0];
  assign wdat   = din_m[WIDTH-1:0];

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .in_i      (gpio_in),
    .in_sync_o (in_sync),
    .rise_o    (rise)
  );

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (we) begin
      unique case (1'b1)
        off == GPIO_OFF_OUT: out_d = (out_q & ~wmask) | wdat;
        off == GPIO_OFF_OE:  oe_d  = (oe_q & ~wmask) | wdat;
        off == GPIO_OFF_SET: out_d = out_q | wdat;
        off == GPIO_OFF_CLR: out_d = out_q & ~wdat;
        off == GPIO_OFF_TOG: out_d = out_q ^ wdat;
        default: ;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] clr;
  logic             unused_ok;

  always_comb begin
    ien_d = ien_q;
    clr   = '0;
    if (we && off == GPIO_OFF_IEN) begin
      ien_d = (ien_q & ~wmask) | wdat;
    end
    if (we && off == GPIO_OFF_STAT) begin
      clr = wdat;
    end
    // OR-ing rise after the clear lets a same-cycle edge win
    stat_d = (stat_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien_q  <= '0;
      stat_q <= '0;
    end else begin
      ien_q  <= ien_d;
      stat_q <= stat_d;
    end
  end

  assign irq       = |(stat_q & ien_q);
  assign ien_rd    = ien_q;
  assign stat_rd   = stat_q;
  assign unused_ok = ^{bus.address[1:0], din_m, lane_m};
`else
  logic unused_ok;

  assign irq       = 1'b0;
  assign ien_rd    = '0;
  assign stat_rd   = '0;
  assign unused_ok = ^{bus.address[1:0], din_m, lane_m, rise};
`endif

  always_comb begin
    rdata_d = '0;
    if (sel) begin
      unique case (off)
        GPIO_OFF_OUT:  rdata_d = 32'(out_q);
        GPIO_OFF_OE:   rdata_d = 32'(oe_q);
        GPIO_OFF_IN:   rdata_d = 32'(in_sync);
        GPIO_OFF_IEN:  rdata_d = 32'(ien_rd);
        GPIO_OFF_STAT: rdata_d = 32'(stat_rd);
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      oe_q    <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpio_out     = out_q;
  assign gpio_oe      = oe_q;
  assign bus.data_out = rdata_q;

endmodule
